// File: rtl/amm_slave_mem_responder_if.sv
// Avalon-MM slave-side bus bundle for amm_slave_mem_responder.
// The master modport is the initiator's view and the slave modport is the responder's view.
interface amm_slave_mem_responder_if #(
  parameter int P_DW = 32,
  parameter int P_AW = 32
);
  logic [P_AW-1:0]   s_address;
  logic [P_DW/8-1:0] s_byteenable;
  logic [P_DW-1:0]   s_writedata;
  logic              s_read;
  logic              s_write;
  logic              s_waitrequest;
  logic [P_DW-1:0]   s_readdata;

  modport master (
    output s_address,
    output s_byteenable,
    output s_writedata,
    output s_read,
    output s_write,
    input  s_waitrequest,
    input  s_readdata
  );

  modport slave (
    input  s_address,
    input  s_byteenable,
    input  s_writedata,
    input  s_read,
    input  s_write,
    output s_waitrequest,
    output s_readdata
  );
endinterface

// File: rtl/amm_slave_mem_responder.sv
// Avalon-MM responder backed by a word-addressed RAM with byte lanes, fixed wait states
// before each acknowledge, and wrapping read and write transfer counters.
module amm_slave_mem_responder #(
  parameter int P_DW    = 32,
  parameter int P_AW    = 32,
  parameter int P_DEPTH = 256,
  parameter int P_WAIT  = 2,
  parameter int P_CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  amm_slave_mem_responder_if.slave s,
  output logic [P_CNTW-1:0]      rd_count,
  output logic [P_CNTW-1:0]      wr_count
);

  localparam int              LP_IW   = $clog2(P_DEPTH);
  localparam int              LP_NB   = P_DW / 8;
  localparam logic [3:0]      LP_WAIT = 4'(P_WAIT);
  localparam logic [P_CNTW-1:0] LP_ONE = {{(P_CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t             r_state;
  logic [3:0]         r_waitCnt;
  logic               r_waitreq;
  logic [P_DW-1:0]    r_readdata;
  logic [P_CNTW-1:0]  r_rdCount;
  logic [P_CNTW-1:0]  r_wrCount;
  logic [P_DW-1:0]    r_mem [P_DEPTH];

  logic [LP_IW-1:0]   w_idx;
  logic               w_req;
  logic               w_rdOnly;
  logic               w_commitWr;
  logic [P_DW-1:0]    w_rdWord;
  logic [P_AW-LP_IW-1:0] w_unusedAddr;

  // Upper address bits alias onto the RAM and the byte offset is ignored.
  assign w_idx        = s.s_address[LP_IW+1:2];
  assign w_unusedAddr = {s.s_address[P_AW-1:LP_IW+2], s.s_address[1:0]};
  assign w_req        = s.s_read | s.s_write;
  assign w_rdOnly     = s.s_read & ~s.s_write;
  assign w_rdWord     = r_mem[w_idx];
  assign w_commitWr   = (r_state == ST_ACK) & s.s_write & ~reset;

  assign s.s_waitrequest = r_waitreq;
  assign s.s_readdata    = r_readdata;
  assign rd_count        = r_rdCount;
  assign wr_count        = r_wrCount;

  // RAM write port: byte lanes commit on the edge that closes the acknowledge cycle.
  always_ff @(posedge clk) begin
    if (w_commitWr) begin
      for (int b = 0; b < LP_NB; b++) begin
        if (s.s_byteenable[b]) begin
          r_mem[w_idx][8*b +: 8] <= s.s_writedata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_waitCnt  <= 4'd0;
      r_waitreq  <= 1'b1;
      r_readdata <= '0;
      r_rdCount  <= '0;
      r_wrCount  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_waitreq  <= 1'b1;
          r_readdata <= '0;
          if (w_req) begin
            r_waitCnt <= LP_WAIT;
            if (P_WAIT > 0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state    <= ST_ACK;
              r_waitreq  <= 1'b0;
              r_readdata <= w_rdOnly ? w_rdWord : '0;
            end
          end
        end

        // A dropped request aborts without touching RAM or counters.
        ST_WAIT: begin
          if (!w_req) begin
            r_state    <= ST_IDLE;
            r_waitCnt  <= 4'd0;
            r_waitreq  <= 1'b1;
            r_readdata <= '0;
          end else if (r_waitCnt <= 4'd1) begin
            r_state    <= ST_ACK;
            r_waitCnt  <= 4'd0;
            r_waitreq  <= 1'b0;
            r_readdata <= w_rdOnly ? w_rdWord : '0;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end

        ST_ACK: begin
          r_state    <= ST_IDLE;
          r_waitCnt  <= 4'd0;
          r_waitreq  <= 1'b1;
          r_readdata <= '0;
          if (s.s_write) begin
            r_wrCount <= r_wrCount + LP_ONE;
          end else if (s.s_read) begin
            r_rdCount <= r_rdCount + LP_ONE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_waitCnt  <= 4'd0;
          r_waitreq  <= 1'b1;
          r_readdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_slave_mem_responder.sv
// Self-checking bench: a 2-wait-state responder with 4-bit counters and a zero-wait responder,
// both checked against a reference memory model and a queue of expected acknowledge data.
module tb_amm_slave_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  amm_slave_mem_responder_if #(.P_DW(32), .P_AW(32)) busA ();
  amm_slave_mem_responder_if #(.P_DW(32), .P_AW(32)) busZ ();

  logic [3:0]  rdCntA, wrCntA;
  logic [15:0] rdCntZ, wrCntZ;

  amm_slave_mem_responder #(
    .P_DW(32), .P_AW(32), .P_DEPTH(256), .P_WAIT(2), .P_CNTW(4)
  ) dut (
    .clk(clk), .reset(reset), .s(busA.slave), .rd_count(rdCntA), .wr_count(wrCntA)
  );

  amm_slave_mem_responder #(
    .P_DW(32), .P_AW(32), .P_DEPTH(256), .P_WAIT(0), .P_CNTW(16)
  ) dutZ (
    .clk(clk), .reset(reset), .s(busZ.slave), .rd_count(rdCntZ), .wr_count(wrCntZ)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] expQ[$];
  logic [31:0] mdl [256];
  int expRd = 0;
  int expWr = 0;

  task automatic idleBus();
    busA.s_address = '0; busA.s_byteenable = '0; busA.s_writedata = '0;
    busA.s_read = 1'b0; busA.s_write = 1'b0;
    busZ.s_address = '0; busZ.s_byteenable = '0; busZ.s_writedata = '0;
    busZ.s_read = 1'b0; busZ.s_write = 1'b0;
  endtask

  // Reference model of a committed write: only enabled byte lanes change.
  task automatic mdlWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [7:0] idx;
    idx = addr[9:2];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end
    expWr++;
  endtask

  // Called just after a rising edge; holds the request until acknowledged, then releases it.
  task automatic busXfer(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output int lat, output logic [31:0] ackData,
                         output bit dataLeak, output bit timedOut);
    busA.s_read = rd; busA.s_write = wr; busA.s_address = addr;
    busA.s_writedata = data; busA.s_byteenable = be;
    lat = 0; dataLeak = 1'b0; timedOut = 1'b1; ackData = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busA.s_waitrequest === 1'b0) begin
        ackData = busA.s_readdata;
        timedOut = 1'b0;
        break;
      end
      if (busA.s_readdata !== 32'h0) dataLeak = 1'b1;
      lat++;
    end
    @(posedge clk); #1;
    busA.s_read = 1'b0; busA.s_write = 1'b0;
  endtask

  task automatic busXferZ(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int lat,
                          output logic [31:0] ackData, output bit dataLeak,
                          output bit timedOut, output time ackTime);
    busZ.s_read = rd; busZ.s_write = wr; busZ.s_address = addr;
    busZ.s_writedata = data; busZ.s_byteenable = 4'hF;
    lat = 0; dataLeak = 1'b0; timedOut = 1'b1; ackData = '0; ackTime = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busZ.s_waitrequest === 1'b0) begin
        ackData = busZ.s_readdata;
        ackTime = $time;
        timedOut = 1'b0;
        break;
      end
      if (busZ.s_readdata !== 32'h0) dataLeak = 1'b1;
      lat++;
    end
    @(posedge clk); #1;
    busZ.s_read = 1'b0; busZ.s_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busA.s_waitrequest, busA.s_readdata, rdCntA, wrCntA} !== {1'b1, 32'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("[TB] FAIL reset_state_a got wr=%b rd=%h rc=%0d wc=%0d want wr=1 rd=0 rc=0 wc=0",
               busA.s_waitrequest, busA.s_readdata, rdCntA, wrCntA);
    end
    total++;
    if ({busZ.s_waitrequest, busZ.s_readdata, rdCntZ, wrCntZ} !== {1'b1, 32'h0, 16'h0, 16'h0}) begin
      bad++;
      $display("[TB] FAIL reset_state_z got wr=%b rd=%h rc=%0d wc=%0d want wr=1 rd=0 rc=0 wc=0",
               busZ.s_waitrequest, busZ.s_readdata, rdCntZ, wrCntZ);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    expRd = 0; expWr = 0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d, e; bit leak, to;
    expQ.push_back(32'h0);
    busXfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, d, leak, to);
    mdlWrite(32'h10, 32'hDEADBEEF, 4'hF);
    e = expQ.pop_front();
    total++;
    if (to || lat !== 3) begin
      bad++; $display("[TB] FAIL basic_wr_latency got=%0d timeout=%0b want=3", lat, to);
    end
    total++;
    if (d !== e) begin bad++; $display("[TB] FAIL basic_wr_ackdata got=%h want=%h", d, e); end

    expQ.push_back(mdl[8'h04]);
    busXfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || lat !== 3) begin
      bad++; $display("[TB] FAIL basic_rd_latency got=%0d timeout=%0b want=3", lat, to);
    end
    total++;
    if (d !== e) begin bad++; $display("[TB] FAIL basic_rd_data got=%h want=%h", d, e); end
    total++;
    if (leak !== 1'b0) begin bad++; $display("[TB] FAIL basic_rd_leak got=%0b want=0", leak); end
    @(negedge clk);
    total++;
    if (busA.s_readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL basic_rd_after_ack got=%h want=0", busA.s_readdata);
    end
    total++;
    if ({rdCntA, wrCntA} !== {4'(expRd), 4'(expWr)}) begin
      bad++; $display("[TB] FAIL basic_counts got rc=%0d wc=%0d want rc=%0d wc=%0d",
                      rdCntA, wrCntA, expRd % 16, expWr % 16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] d, e; bit leak, to;
    busXfer(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, d, leak, to);
    mdlWrite(32'h20, 32'h11223344, 4'hF);
    busXfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, lat, d, leak, to);
    mdlWrite(32'h20, 32'hAABBCCDD, 4'h5);
    expQ.push_back(mdl[8'h08]);
    busXfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL byte_lanes got=%h want=%h", d, e); end
    total++;
    if (d !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL byte_lanes_const got=%h want=11bb33dd", d); end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] d, e; bit leak, to;
    busXfer(1'b0, 1'b1, 32'h400, 32'h1, 4'hF, lat, d, leak, to);
    mdlWrite(32'h400, 32'h1, 4'hF);
    expQ.push_back(mdl[8'h00]);
    busXfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL alias_upper got=%h want=%h", d, e); end
    expQ.push_back(mdl[8'h00]);
    busXfer(1'b1, 1'b0, 32'h3, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL alias_lowbits got=%h want=%h", d, e); end
  endtask

  task automatic test_zero_wait();
    int lat1, lat2; logic [31:0] d1, d2, e; bit leak1, leak2, to1, to2; time t1, t2;
    busXferZ(1'b0, 1'b1, 32'h40, 32'hCAFE0001, lat1, d1, leak1, to1, t1);
    busXferZ(1'b0, 1'b1, 32'h44, 32'hCAFE0002, lat1, d1, leak1, to1, t1);
    expQ.push_back(32'hCAFE0001);
    expQ.push_back(32'hCAFE0002);
    busXferZ(1'b1, 1'b0, 32'h40, 32'h0, lat1, d1, leak1, to1, t1);
    busXferZ(1'b1, 1'b0, 32'h44, 32'h0, lat2, d2, leak2, to2, t2);
    e = expQ.pop_front();
    total++;
    if (to1 || d1 !== e) begin bad++; $display("[TB] FAIL zw_read0 got=%h want=%h", d1, e); end
    e = expQ.pop_front();
    total++;
    if (to2 || d2 !== e) begin bad++; $display("[TB] FAIL zw_read1 got=%h want=%h", d2, e); end
    total++;
    if (lat1 !== 1 || lat2 !== 1) begin
      bad++; $display("[TB] FAIL zw_latency got=%0d,%0d want=1,1", lat1, lat2);
    end
    total++;
    if (t2 - t1 !== 20) begin bad++; $display("[TB] FAIL zw_period got=%0t want=20", t2 - t1); end
    total++;
    if (leak1 || leak2) begin bad++; $display("[TB] FAIL zw_idle_data got=%0b%0b want=00", leak1, leak2); end
    total++;
    if ({rdCntZ, wrCntZ} !== {16'd2, 16'd2}) begin
      bad++; $display("[TB] FAIL zw_counts got rc=%0d wc=%0d want rc=2 wc=2", rdCntZ, wrCntZ);
    end
  endtask

  task automatic test_simultaneous();
    int lat; logic [31:0] d, e; bit leak, to;
    expQ.push_back(32'h0);
    busXfer(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, lat, d, leak, to);
    mdlWrite(32'h30, 32'h5A5A5A5A, 4'hF);
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL simul_readdata got=%h want=%h", d, e); end
    total++;
    if ({rdCntA, wrCntA} !== {4'(expRd), 4'(expWr)}) begin
      bad++; $display("[TB] FAIL simul_counts got rc=%0d wc=%0d want rc=%0d wc=%0d",
                      rdCntA, wrCntA, expRd % 16, expWr % 16);
    end
  endtask

  task automatic test_reset_midwrite();
    int lat; logic [31:0] d, e; bit leak, to;
    busA.s_write = 1'b1; busA.s_read = 1'b0; busA.s_address = 32'h30;
    busA.s_writedata = 32'h0; busA.s_byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    idleBus();
    @(negedge clk);
    total++;
    if ({busA.s_waitrequest, busA.s_readdata, rdCntA, wrCntA} !== {1'b1, 32'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("[TB] FAIL midwrite_reset got wr=%b rd=%h rc=%0d wc=%0d want wr=1 rd=0 rc=0 wc=0",
               busA.s_waitrequest, busA.s_readdata, rdCntA, wrCntA);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    expRd = 0; expWr = 0;
    expQ.push_back(mdl[8'h0C]);
    busXfer(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL midwrite_kept got=%h want=%h", d, e); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] d, e; bit leak, to;
    busA.s_write = 1'b1; busA.s_address = 32'h30;
    busA.s_writedata = 32'hFFFFFFFF; busA.s_byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    busA.s_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (busA.s_waitrequest !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_waitreq got=%b want=1", busA.s_waitrequest);
    end
    @(posedge clk); #1;
    expQ.push_back(mdl[8'h0C]);
    busXfer(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, d, leak, to);
    expRd++;
    e = expQ.pop_front();
    total++;
    if (to || d !== e) begin bad++; $display("[TB] FAIL abort_no_write got=%h want=%h", d, e); end
    total++;
    if ({rdCntA, wrCntA} !== {4'(expRd), 4'(expWr)}) begin
      bad++; $display("[TB] FAIL abort_counts got rc=%0d wc=%0d want rc=%0d wc=%0d",
                      rdCntA, wrCntA, expRd % 16, expWr % 16);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] d, e, addr, data; bit leak, to; logic [3:0] be; int op;
    for (int i = 0; i < 256; i++) begin
      data = $urandom;
      addr = {$urandom_range(0, 255)} << 10 | (i << 2);
      busXfer(1'b0, 1'b1, addr, data, 4'hF, lat, d, leak, to);
      mdlWrite(addr, data, 4'hF);
    end
    for (int i = 0; i < 10000; i++) begin
      op = $urandom_range(0, 3);
      addr = $urandom;
      data = $urandom;
      be = 4'($urandom_range(0, 15));
      if (op <= 1) begin
        expQ.push_back(mdl[addr[9:2]]);
        busXfer(1'b1, 1'b0, addr, data, be, lat, d, leak, to);
        expRd++;
      end else begin
        expQ.push_back(32'h0);
        busXfer(op == 3, 1'b1, addr, data, be, lat, d, leak, to);
        mdlWrite(addr, data, be);
      end
      e = expQ.pop_front();
      total++;
      if (to || d !== e) begin
        bad++; $display("[TB] FAIL rand_data[%0d] op=%0d addr=%h got=%h want=%h", i, op, addr, d, e);
      end
      total++;
      if (lat !== 3 || leak) begin
        bad++; $display("[TB] FAIL rand_timing[%0d] got lat=%0d leak=%0b want lat=3 leak=0", i, lat, leak);
      end
      total++;
      if ({rdCntA, wrCntA} !== {4'(expRd), 4'(expWr)}) begin
        bad++; $display("[TB] FAIL rand_counts[%0d] got rc=%0d wc=%0d want rc=%0d wc=%0d",
                        i, rdCntA, wrCntA, expRd % 16, expWr % 16);
      end
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idleBus();
    test_reset();
    test_basic();
    test_byte_lanes();
    test_alias();
    test_zero_wait();
    test_simultaneous();
    test_reset_midwrite();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
